// File: rtl/cpu_data_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_data (package)
//  Description : Shared definitions for the interrupt controller: FSM state
//                encoding, configuration register addresses and a one-hot
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_data;

    localparam int NUM_IRQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK       = 2'd0;
    localparam logic [1:0] ADDR_PENDING    = 2'd1;
    localparam logic [1:0] ADDR_IN_SERVICE = 2'd2;
    localparam logic [1:0] ADDR_SWTRIG     = 2'd3;

    function automatic logic [NUM_IRQ-1:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : irq_priority_encoder
//  Description : Fixed-priority winner select, bit 0 highest. Combinational.
//  Ports       : in    - candidate request vector
//                valid - any bit of in is set
//                index - lowest set bit index (0 when none set)
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_encoder (
    input  logic [7:0] in,
    output logic       valid,
    output logic [2:0] index
);

    always_comb begin
        valid = |in;
        index = 3'd0;
        // Scan from lowest priority upward so the last hit is the lowest index.
        for (int i = 7; i >= 0; i--) begin
            if (in[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : 8-line edge-triggered interrupt controller with mask,
//                pending, in-service and software-trigger registers and a
//                non-nesting IDLE/REQUEST/SERVICE handshake with the CPU.
//  Ports       : clk, reset (async, active-high)
//                irq_in    - asynchronous rising-edge interrupt lines
//                cfg_we/cfg_addr/cfg_wdata/cfg_rdata - register access
//                ack, eoi  - CPU accept / end-of-interrupt pulses
//                irq, vector, busy - request, requested line, in service
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import cpu_data::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [2:0] vector,
    output logic       busy
);

    logic [7:0] sync1_q, sync2_q, prev_q;
    logic [7:0] armed_q, armed_d;
    logic [1:0] settle_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] in_service_q, in_service_d;
    logic [2:0] vector_q, vector_d;
    state_e     state_q, state_d;

    logic [7:0] w_rise, w_sw_set, w_cfg_clr, w_ack_clr;
    logic       w_take, w_valid;
    logic [2:0] w_index;

    irq_priority_encoder u_prio (
        .in    (pending_q & mask_q),
        .valid (w_valid),
        .index (w_index)
    );

    // A line only becomes eligible for edge detection once the synchroniser
    // has carried a genuinely sampled low; settle_q marks when sync2_q holds
    // real data rather than its reset value, so a line held high through
    // reset never produces a spurious edge.
    always_comb begin
        armed_d   = armed_q | (~sync2_q & {8{settle_q[1]}});
        w_rise    = sync2_q & ~prev_q & armed_q;
        w_sw_set  = (cfg_we && cfg_addr == ADDR_SWTRIG)  ? cfg_wdata : 8'h00;
        w_cfg_clr = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : 8'h00;
        w_take    = (state_q == ST_REQUEST) && ack;
        w_ack_clr = w_take ? onehot8(vector_q) : 8'h00;
        // Sets are OR-ed in after clears so a coincident set wins.
        pending_d = (pending_q & ~(w_cfg_clr | w_ack_clr)) | w_rise | w_sw_set;
        mask_d    = (cfg_we && cfg_addr == ADDR_MASK) ? cfg_wdata : mask_q;
    end

    always_comb begin
        state_d      = state_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    state_d  = ST_REQUEST;
                    vector_d = w_index;
                end
            end
            ST_REQUEST: begin
                // The request is held until ack regardless of mask/pending.
                if (ack) begin
                    state_d      = ST_SERVICE;
                    in_service_d = onehot8(vector_q);
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d      = ST_IDLE;
                    in_service_d = 8'h00;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 8'h00;
            sync2_q      <= 8'h00;
            prev_q       <= 8'h00;
            armed_q      <= 8'h00;
            settle_q     <= 2'b00;
            pending_q    <= 8'h00;
            mask_q       <= 8'h00;
            in_service_q <= 8'h00;
            vector_q     <= 3'd0;
            state_q      <= ST_IDLE;
        end else begin
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            armed_q      <= armed_d;
            settle_q     <= {settle_q[0], 1'b1};
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            vector_q     <= vector_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        case (cfg_addr)
            ADDR_MASK:       cfg_rdata = mask_q;
            ADDR_PENDING:    cfg_rdata = pending_q;
            ADDR_IN_SERVICE: cfg_rdata = in_service_q;
            default:         cfg_rdata = 8'h00;
        endcase
    end

    assign irq    = (state_q == ST_REQUEST);
    assign busy   = (state_q == ST_SERVICE);
    assign vector = vector_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Self-checking bench for interrupt_controller. A behavioural
//                model tracks registers and the request handshake from the
//                sampled input history; directed sequences add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_in = 8'h00;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'h00;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    wire  [7:0] cfg_rdata;
    wire        irq;
    wire  [2:0] vector;
    wire        busy;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ack       (ack),
        .eoi       (eoi),
        .irq       (irq),
        .vector    (vector),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_pend, m_mask, m_insvc;
    bit         m_req, m_svc;
    int         m_vec;
    logic [7:0] hist [3];
    int         nsamp;
    logic [7:0] m_rise, m_set, m_clr, m_live;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return m_insvc;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 0; m_mask = 0; m_insvc = 0;
            m_req = 0; m_svc = 0; m_vec = 0;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
            nsamp = 0;
        end else begin
            // A rise counts when the sample two edges ago was high and the
            // one before it was a real low taken after reset.
            m_rise = (nsamp >= 3) ? (hist[1] & ~hist[2]) : 8'h00;
            m_set  = m_rise | ((cfg_we && cfg_addr == 2'd3) ? cfg_wdata : 8'h00);
            m_clr  = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 8'h00;
            m_live = m_pend & m_mask;
            if (m_req && ack) begin
                m_clr   = m_clr | (8'h01 << m_vec);
                m_req   = 0;
                m_svc   = 1;
                m_insvc = 8'h01 << m_vec;
            end else if (m_svc && eoi) begin
                m_svc   = 0;
                m_insvc = 0;
            end else if (!m_req && !m_svc && m_live != 0) begin
                m_req = 1;
                m_vec = lowest(m_live);
            end
            m_pend = (m_pend & ~m_clr) | m_set;
            if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_in;
            nsamp++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(posedge clk);
        #3;
        check("irq", irq, m_req);
        check("busy", busy, m_svc);
        if (m_req) check("vector", vector, m_vec);
        check("cfg_rdata", cfg_rdata, m_read(cfg_addr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_wdata = 8'h00;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        check(name, irq, 1'b1);
    endtask

    logic [7:0] r;

    initial begin
        // Reset and settle
        tick(3);
        rd(2'd0, r); check("reset_mask", r, 8'h00);
        check("reset_irq", irq, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        tick(4);

        // Single line 5
        cfg_write(2'd0, 8'hFF);
        irq_in[5] = 1'b1;
        tick(3);
        check("l5_irq_before_E3", irq, 1'b0);
        rd(2'd1, r); check("l5_pending", r, 8'h20);
        tick();
        check("l5_irq_after_E3", irq, 1'b1);
        check("l5_vector", vector, 3'd5);
        pulse_ack();
        rd(2'd1, r); check("l5_pending_cleared", r, 8'h00);
        rd(2'd2, r); check("l5_in_service", r, 8'h20);
        check("l5_busy", busy, 1'b1);
        check("l5_irq_dropped", irq, 1'b0);
        pulse_eoi();
        check("l5_busy_done", busy, 1'b0);
        irq_in[5] = 1'b0;
        tick(4);

        // Lines 6 and 2 together
        irq_in = 8'h44;
        wait_irq("p_first_timeout");
        check("p_first_vector", vector, 3'd2);
        pulse_ack(); pulse_eoi();
        wait_irq("p_second_timeout");
        check("p_second_vector", vector, 3'd6);
        pulse_ack(); pulse_eoi();
        irq_in = 8'h00;
        tick(4);

        // Ack/eoi while idle are ignored
        pulse_ack(); pulse_eoi();
        check("idle_busy", busy, 1'b0);

        // Software trigger with mask closed
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd3, 8'h80);
        tick(4);
        rd(2'd1, r); check("sw_pending", r, 8'h80);
        rd(2'd3, r); check("sw_reads_zero", r, 8'h00);
        check("sw_masked_irq", irq, 1'b0);
        cfg_write(2'd0, 8'h80);
        wait_irq("sw_timeout");
        check("sw_vector", vector, 3'd7);
        pulse_ack(); pulse_eoi();

        // Request held through mask and pending removal
        cfg_write(2'd0, 8'hFF);
        cfg_write(2'd3, 8'h08);
        wait_irq("hold_timeout");
        check("hold_vector", vector, 3'd3);
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd1, 8'h08);
        tick(3);
        check("hold_irq", irq, 1'b1);
        check("hold_vector_stable", vector, 3'd3);
        pulse_ack();
        check("hold_irq_after_ack", irq, 1'b0);
        pulse_eoi();
        cfg_write(2'd0, 8'hFF);

        // Ack on line 4 coinciding with a fresh synchronised edge on line 4
        cfg_write(2'd3, 8'h10);
        wait_irq("merge_timeout");
        check("merge_vector", vector, 3'd4);
        irq_in[4] = 1'b1;
        tick(2);
        pulse_ack();
        rd(2'd1, r); check("merge_pending_kept", r, 8'h10);
        check("merge_busy", busy, 1'b1);
        pulse_eoi();
        wait_irq("merge_again_timeout");
        check("merge_again_vector", vector, 3'd4);
        pulse_ack(); pulse_eoi();
        irq_in[4] = 1'b0;
        tick(4);

        // Reset in SERVICE with line 1 held high
        irq_in[1] = 1'b1;
        wait_irq("rst_timeout");
        check("rst_vector", vector, 3'd1);
        pulse_ack();
        check("rst_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_irq", irq, 1'b0);
        check("rst_busy", busy, 1'b0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r); check("rst_reg", r, 8'h00);
        end
        tick(2);
        reset = 1'b0;
        cfg_write(2'd0, 8'hFF);
        tick(8);
        check("rst_no_request", irq, 1'b0);
        rd(2'd1, r); check("rst_no_pending", r, 8'h00);
        irq_in[1] = 1'b0;
        tick(4);
        irq_in[1] = 1'b1;
        wait_irq("rst_fresh_timeout");
        check("rst_fresh_vector", vector, 3'd1);
        pulse_ack(); pulse_eoi();
        irq_in = 8'h00;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have these ports; clock and reset are decided as: reset reset, asynchronous, active-high; clock clk.
- clk  in  1  system clock, rising edge active
- reset  in  1  asynchronous active-high reset
- irq_in  in  8  peripheral interrupt lines, asynchronous, rising-edge triggered
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_addr  in  2  configuration register select
- cfg_wdata  in  8  configuration write data
- cfg_rdata  out  8  configuration read data, combinational from cfg_addr
- ack  in  1  CPU accepted the interrupt, one-cycle pulse
- eoi  in  1  CPU finished the handler, one-cycle pulse
- irq  out  1  interrupt request to the CPU
- vector  out  3  number of the requested line, valid while irq=1
- busy  out  1  a handler is in service

Function
REQ-002 Each irq_in bit SHALL pass through a 2-flop synchroniser. A third flop SHALL hold the previous synchronised value, and a 0->1 transition between them SHALL set the matching pending bit.
REQ-003 Latency: an irq_in rise set up before rising edge E0 SHALL set pending after E2, and SHALL assert irq after E3 when the line is unmasked and the FSM is IDLE.
REQ-004 Register map:
- addr0 MASK, read/write; 1 = enabled.
- addr1 PENDING; reads pending; a write of 1 clears that bit.
- addr2 IN_SERVICE, read-only; a write has no effect.
- addr3 SWTRIG; reads 0x00; a write of 1 sets that pending bit.
REQ-005 Priority SHALL be fixed: bit 0 is highest, bit 7 is lowest. The winner SHALL be the lowest-index bit of (pending & MASK).
REQ-006 The FSM SHALL have three states: IDLE, REQUEST, SERVICE.
REQ-007 IDLE->REQUEST SHALL occur when (pending & MASK) != 0. On this transition the winner index SHALL be latched into vector.
REQ-008 In REQUEST, irq SHALL be 1 and vector SHALL be stable.
REQ-009 REQUEST->SERVICE SHALL occur on ack. On the same edge, pending[vector] SHALL be cleared, in_service[vector] SHALL be set, and irq SHALL be 0 in the next cycle.
REQ-010 SERVICE->IDLE SHALL occur on eoi, and in_service SHALL be cleared. There is no nesting: no new irq SHALL be raised while in SERVICE.
REQ-011 Once irq is asserted, it SHALL NOT be retracted before ack. This holds even if MASK or PENDING writes remove the source, and vector stays latched.
REQ-012 eoi outside SERVICE and ack outside REQUEST SHALL be ignored.
REQ-013 Simultaneous events SHALL resolve as follows:
- Set (edge or SWTRIG) and clear (PENDING write or ack) on the same bit in the same cycle: set wins, and the bit stays 1.
- ack and eoi together: ack is handled and eoi is ignored.
REQ-014 An edge on a line that is pending or in service SHALL merge into a single pending bit. No counting is done.
REQ-015 Masked lines SHALL still latch pending, and SHALL request once unmasked.
REQ-016 busy SHALL equal (state == SERVICE).

Reset
REQ-017 Asserting reset SHALL immediately clear all of the following, including mid-operation in any FSM state: synchroniser flops, pending, MASK, in_service, and the vector register. The state SHALL become IDLE and irq SHALL become 0.
REQ-018 After reset deassertion, no edge SHALL be detected on an irq_in line that is already high. The edge detector SHALL start from 0 and require a fresh rise after the synchroniser has captured a low level.

Structure
REQ-019 The state encodings (IDLE=0, REQUEST=1, SERVICE=2) and the register addresses (MASK=0, PENDING=1, IN_SERVICE=2, SWTRIG=3) SHALL live in the shared cpu_data package.
REQ-020 The winner selection SHALL be a sub-module irq_priority_encoder with these ports:
- in  8-bit input
- valid  1-bit output
- index  3-bit output
It SHALL be purely combinational.

Verification
REQ-021 Sequence: MASK=0xFF, raise irq_in[5]. Required: irq=1 and vector=5 after E3; ack clears PENDING bit 5 and sets IN_SERVICE=0x20; eoi returns busy=0.
REQ-022 Raise irq_in[6] and irq_in[2] in the same cycle with MASK=0xFF. Required: vector=2 first; after ack+eoi, vector=6.
REQ-023 Sequence: MASK=0x00, SWTRIG write 0x80. Required: PENDING reads 0x80 and irq stays 0; then MASK write 0x80 gives irq=1 and vector=7.
REQ-024 In REQUEST with vector=3, write MASK=0x00. Required: irq stays 1 until ack.
REQ-025 In one cycle, an ack for vector 4 and a new synchronised edge on line 4. Required: PENDING bit 4 stays 1 after ack, and line 4 is requested again after eoi.
REQ-026 Pulse reset while in SERVICE with irq_in[1] held high. Required: all registers read 0x00, irq=0, busy=0, and no request appears until irq_in[1] falls and rises again.
